// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR flip-flop command driver.
//   - command op encodings carried through the FIFO
//   - driver FSM states
//   - resolve_op(): maps a queued op plus the tracked flop state to a pulse action
package sr_drv_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_RSVD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_SET  = 2'd1,
        ACT_CLR  = 2'd2
    } act_e;

    // A toggle only has meaning once the flop state is known; reserved ops never act.
    function automatic act_e resolve_op(input logic [OP_W-1:0] op,
                                        input logic            q_known,
                                        input logic            q_exp);
        act_e act;
        act = ACT_NONE;
        case (op)
            OP_SET:  act = ACT_SET;
            OP_CLR:  act = ACT_CLR;
            OP_TGL:  if (q_known) act = q_exp ? ACT_CLR : ACT_SET;
            default: act = ACT_NONE;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous FIFO buffering queued SR commands.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write data_i (ignored when full)
//   data_i     : entry to write
//   pop_i      : drop the head entry (ignored when empty)
//   data_o     : head entry (valid when !empty_o)
//   full_o     : no free slot
//   empty_o    : no entry stored
//   count_o    : number of stored entries
module sr_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sr_cmd_driver.sv
// Command stage for the SR flip-flop: queues set/clear/toggle requests and
// replays each as a timed s or r pulse followed by an idle gap, tracking the
// flop state it expects. s and r are never driven high together.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cmd_valid    : command request
//   cmd_op       : 00 reserved, 01 clear, 10 set, 11 toggle
//   cmd_ready    : FIFO has a free slot
//   s, r         : registered set / reset drive to the flop
//   busy         : commands queued or a pulse/gap in progress
//   q_exp        : expected flop output
//   q_known      : q_exp is valid
//   err_illegal  : one-cycle pulse when a command is dropped
module sr_cmd_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [OP_W-1:0] cmd_op,
    output logic            cmd_ready,
    output logic            s,
    output logic            r,
    output logic            busy,
    output logic            q_exp,
    output logic            q_known,
    output logic            err_illegal
);

    localparam int unsigned MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned FCNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_LD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] PULSE_LD_V = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD_V   = CNT_W'(GAP_LD);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              q_exp_q, q_exp_d;
    logic              q_known_q, q_known_d;
    logic              err_q, err_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [OP_W-1:0]   fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    act_e              head_act;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    sr_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (cmd_op),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_act = resolve_op(fifo_data, q_known_q, q_exp_q);

    // State, timer and drive registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            q_exp_q   <= 1'b0;
            q_known_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            q_exp_q   <= q_exp_d;
            q_known_q <= q_known_d;
            err_q     <= err_d;
        end
    end

    // Next-state: pop/decode in IDLE, time the pulse, then time the gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        r_d       = r_q;
        q_exp_d   = q_exp_q;
        q_known_d = q_known_q;
        err_d     = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (head_act)
                        ACT_SET: begin
                            s_d     = 1'b1;
                            cnt_d   = PULSE_LD_V;
                            state_d = PULSE;
                        end
                        ACT_CLR: begin
                            r_d     = 1'b1;
                            cnt_d   = PULSE_LD_V;
                            state_d = PULSE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            PULSE: begin
                if (cnt_q == '0) begin
                    // The flop has latched the pulse: s_q tells which way it went.
                    s_d       = 1'b0;
                    r_d       = 1'b0;
                    q_exp_d   = s_q;
                    q_known_d = 1'b1;
                    if (GAP_CYC > 0) begin
                        cnt_d   = GAP_LD_V;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                s_d     = 1'b0;
                r_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign s           = s_q;
    assign r           = r_q;
    assign q_exp       = q_exp_q;
    assign q_known     = q_known_q;
    assign err_illegal = err_q;
    assign busy        = (fifo_count != '0) || (state_q != IDLE);

endmodule
